// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: generic valid/ready pipeline-stage register.
// Carries an opaque payload between two stages. It supports flush (drop all
// held entries) and a global pause (rdy=0 freezes all state).
// SKID_EN=1 builds a 2-entry skid buffer, so in_ready is a register output.
// SKID_EN=0 builds a single register, and in_ready is combinational.
module pipe_skid_stage #(
  parameter int                     PAYLOAD_W   = 119,
  parameter bit                     SKID_EN     = 1'b1,
  parameter logic [PAYLOAD_W-1:0]   NOP_PAYLOAD = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [1:0]           occupancy
);

  typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} occ_e;

  logic in_fire, out_fire;

  // A transfer happens only while the pipeline is not paused.
  assign in_fire  = in_valid  & in_ready  & rdy;
  assign out_fire = out_valid & out_ready & rdy;

  if (SKID_EN) begin : gen_skid
    occ_e                 state_q, state_d;
    logic [PAYLOAD_W-1:0] head_q, head_d, skid_q, skid_d;
    logic                 in_ready_q, in_ready_d;

    // State register: rst has top priority, and rdy=0 holds every register.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q    <= EMPTY;
        head_q     <= NOP_PAYLOAD;
        skid_q     <= NOP_PAYLOAD;
        in_ready_q <= 1'b1;
      end else if (rdy) begin
        state_q    <= state_d;
        head_q     <= head_d;
        skid_q     <= skid_d;
        in_ready_q <= in_ready_d;
      end
    end

    // Next-state logic. Flush wins over a same-cycle accept.
    always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY: if (in_fire) begin
            state_d = HALF;
            head_d  = in_data;
          end
          HALF: begin
            if (in_fire && !out_fire) begin
              state_d = FULL;
              skid_d  = in_data;
            end else if (out_fire && !in_fire) begin
              state_d = EMPTY;
            end else if (in_fire && out_fire) begin
              head_d  = in_data;
            end
          end
          FULL: if (out_fire) begin
            // The skid entry moves up to the head.
            state_d = HALF;
            head_d  = skid_q;
          end
          default: state_d = EMPTY;
        endcase
      end
      // in_ready is registered from next occupancy, so out_ready never reaches it combinationally.
      in_ready_d = (state_d != FULL);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_valid ? head_q : NOP_PAYLOAD;
    assign occupancy = state_q;
  end else begin : gen_reg
    logic                 valid_q, valid_d;
    logic [PAYLOAD_W-1:0] head_q, head_d;

    // Single-entry register, frozen while paused.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        head_q  <= NOP_PAYLOAD;
      end else if (rdy) begin
        valid_q <= valid_d;
        head_q  <= head_d;
      end
    end

    // An accept overwrites the entry, whether or not the entry was popped in the same cycle.
    always_comb begin
      valid_d = valid_q;
      head_d  = head_q;
      if (flush) begin
        valid_d = 1'b0;
      end else if (in_fire) begin
        valid_d = 1'b1;
        head_d  = in_data;
      end else if (out_fire) begin
        valid_d = 1'b0;
      end
    end

    assign in_ready  = !valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = valid_q ? head_q : NOP_PAYLOAD;
    assign occupancy = {1'b0, valid_q};
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed vectors for the skid (SKID_EN=1) and single-register (SKID_EN=0) builds.
module tb_pipe_skid_stage;
  localparam int          W   = 16;
  localparam logic [W-1:0] NOP = 16'hF00D;

  logic         clk = 1'b0;
  logic         rst, rdy, flush;
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [W-1:0] a_in_data, a_out_data;
  logic [1:0]   a_occ;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [W-1:0] b_in_data, b_out_data;
  logic [1:0]   b_occ;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.PAYLOAD_W(W), .SKID_EN(1'b1), .NOP_PAYLOAD(NOP)) u_a (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ));

  pipe_skid_stage #(.PAYLOAD_W(W), .SKID_EN(1'b0), .NOP_PAYLOAD(NOP)) u_b (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the whole visible state of the skid instance.
  task automatic chk_a(input string tag, input logic [1:0] occ, input logic vld,
                       input logic [W-1:0] dat, input logic ir);
    chk({tag, ".occ"},  32'(a_occ),       32'(occ));
    chk({tag, ".vld"},  32'(a_out_valid), 32'(vld));
    chk({tag, ".data"}, 32'(a_out_data),  32'(dat));
    chk({tag, ".irdy"}, 32'(a_in_ready),  32'(ir));
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    step();
    chk_a("rst0", 2'd0, 1'b0, NOP, 1'b1);
    chk("rst0.b_occ", 32'(b_occ), 32'd0);
    chk("rst0.b_data", 32'(b_out_data), 32'(NOP));
    rst = 1'b0;

    // Fill the skid stage to FULL, then reset it.
    a_in_valid = 1'b1; a_in_data = 16'h000A; step();
    a_in_data = 16'h000B; step();
    chk_a("fill", 2'd2, 1'b1, 16'h000A, 1'b0);
    a_in_valid = 1'b0; rst = 1'b1; step();
    chk_a("rst_full", 2'd0, 1'b0, NOP, 1'b1);
    rst = 1'b0;

    // Stream: back-to-back data with no backpressure.
    a_out_ready = 1'b1; a_in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_in_data = 16'(i);
      step();
      chk_a($sformatf("stream%0d", i), 2'd1, 1'b1, 16'(i), 1'b1);
    end
    a_in_valid = 1'b0; step();
    chk_a("stream_drain", 2'd0, 1'b0, NOP, 1'b1);

    // Backpressure: A and B are held, C waits, then all three drain in order.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h000A; step();
    chk_a("bp_a", 2'd1, 1'b1, 16'h000A, 1'b1);
    a_in_data = 16'h000B; step();
    chk_a("bp_b", 2'd2, 1'b1, 16'h000A, 1'b0);
    a_in_data = 16'h000C; step();
    chk_a("bp_hold", 2'd2, 1'b1, 16'h000A, 1'b0);
    a_out_ready = 1'b1; step();
    chk_a("bp_pop_a", 2'd1, 1'b1, 16'h000B, 1'b1);
    step();
    chk_a("bp_pop_b", 2'd1, 1'b1, 16'h000C, 1'b1);
    a_in_valid = 1'b0; step();
    chk_a("bp_pop_c", 2'd0, 1'b0, NOP, 1'b1);

    // Flush: a FULL stage is flushed while C is presented; C is dropped.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h000A; step();
    a_in_data = 16'h000B; step();
    chk("fl_full", 32'(a_occ), 32'd2);
    a_in_data = 16'h000C; flush = 1'b1; step();
    chk_a("flush", 2'd0, 1'b0, NOP, 1'b1);
    flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1; step();
    chk_a("flush_after", 2'd0, 1'b0, NOP, 1'b1);

    // Pause: a HALF stage holds through rdy=0, even with flush asserted.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h0005; step();
    chk_a("pz_half", 2'd1, 1'b1, 16'h0005, 1'b1);
    rdy = 1'b0; flush = 1'b1; a_in_data = 16'h0006; a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a($sformatf("pause%0d", i), 2'd1, 1'b1, 16'h0005, 1'b1);
    end
    rdy = 1'b1; flush = 1'b0; step();
    chk_a("pz_resume", 2'd1, 1'b1, 16'h0006, 1'b1);
    a_in_valid = 1'b0; step();
    chk_a("pz_drain", 2'd0, 1'b0, NOP, 1'b1);

    // Single-register build: in_ready is combinational, and an accept replaces the held entry.
    b_in_valid = 1'b1; b_in_data = 16'h0011; b_out_ready = 1'b0; step();
    chk("b_hold.occ", 32'(b_occ), 32'd1);
    chk("b_hold.data", 32'(b_out_data), 32'h11);
    chk("b_hold.irdy", 32'(b_in_ready), 32'd0);
    b_in_data = 16'h0022; step();
    chk("b_stall.data", 32'(b_out_data), 32'h11);
    b_out_ready = 1'b1; #1;
    chk("b_comb.irdy", 32'(b_in_ready), 32'd1);
    step();
    chk("b_repl.data", 32'(b_out_data), 32'h22);
    chk("b_repl.occ", 32'(b_occ), 32'd1);
    b_in_valid = 1'b0; step();
    chk("b_drain.occ", 32'(b_occ), 32'd0);
    chk("b_drain.data", 32'(b_out_data), 32'(NOP));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
